// File: rtl/pixel_scheduler_if.sv
// Scheduler-side bundle: frame configuration, depth-engine start/done link and the outgoing pixel stream.
// The master modport is the scheduler; the slave modport is the surrounding engine/stream environment.
interface pixel_scheduler_if #(
    parameter int WORD_LENGTH = 16
);
    logic                   frame_start;
    logic [WORD_LENGTH-1:0] re_min;
    logic [WORD_LENGTH-1:0] im_max;
    logic [WORD_LENGTH-1:0] step;
    logic [9:0]             max_iter_in;

    logic                   calc_start;
    logic [9:0]             calc_x;
    logic [8:0]             calc_y;
    logic [WORD_LENGTH-1:0] calc_re_c;
    logic [WORD_LENGTH-1:0] calc_im_c;
    logic [9:0]             calc_max_iter;
    logic                   calc_done;
    logic [9:0]             calc_depth;

    logic                   pix_valid;
    logic                   pix_ready;
    logic [9:0]             pix_x;
    logic [8:0]             pix_y;
    logic [9:0]             pix_depth;
    logic                   pix_last;
    logic                   busy;

    modport master (
        input  frame_start, re_min, im_max, step, max_iter_in,
        output calc_start, calc_x, calc_y, calc_re_c, calc_im_c, calc_max_iter,
        input  calc_done, calc_depth,
        output pix_valid, pix_x, pix_y, pix_depth, pix_last, busy,
        input  pix_ready
    );

    modport slave (
        output frame_start, re_min, im_max, step, max_iter_in,
        input  calc_start, calc_x, calc_y, calc_re_c, calc_im_c, calc_max_iter,
        output calc_done, calc_depth,
        input  pix_valid, pix_x, pix_y, pix_depth, pix_last, busy,
        output pix_ready
    );
endinterface

// File: rtl/pixel_scheduler.sv
// Raster-order feeder for one Mandelbrot depth engine, one pixel in flight: start pulse, wait for done edge,
// then hold the pixel on a valid/ready stream; pix_ready low stalls the walk and no new start is issued.
module pixel_scheduler #(
    parameter int WORD_LENGTH = 16,
    parameter int FRAC        = 8,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480
) (
    input  logic               sysclk,
    input  logic               reset_n,
    pixel_scheduler_if.master  bus
);
    if (FRAC >= WORD_LENGTH || H_RES < 1 || H_RES > 1024 || V_RES < 1 || V_RES > 512) begin : g_param_check
        $error("pixel_scheduler: unsupported parameter set");
    end

    localparam logic [9:0] X_LAST = 10'(H_RES - 1);
    localparam logic [8:0] Y_LAST = 9'(V_RES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_OUTPUT
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [9:0]             x;
    logic [8:0]             y;
    logic [WORD_LENGTH-1:0] re_acc;
    logic [WORD_LENGTH-1:0] im_acc;
    logic [WORD_LENGTH-1:0] re_min_q;
    logic [WORD_LENGTH-1:0] step_q;
    logic [9:0]             max_iter_q;
    logic [9:0]             depth_q;
    logic                   done_q;
    logic                   complete;
    logic                   last_pix;

    // Only a rising done counts: the engine holds done high until its next start.
    assign complete = (state == ST_WAIT) && bus.calc_done && !done_q;
    assign last_pix = (x == X_LAST) && (y == Y_LAST);

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus.frame_start) state_nxt = ST_ISSUE;
            ST_ISSUE:  state_nxt = ST_WAIT;
            ST_WAIT:   if (complete) state_nxt = ST_OUTPUT;
            ST_OUTPUT: if (bus.pix_ready) state_nxt = last_pix ? ST_IDLE : ST_ISSUE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            x          <= '0;
            y          <= '0;
            re_acc     <= '0;
            im_acc     <= '0;
            re_min_q   <= '0;
            step_q     <= '0;
            max_iter_q <= '0;
            depth_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state == ST_ISSUE) ? 1'b0 : bus.calc_done;
            case (state)
                ST_IDLE: begin
                    if (bus.frame_start) begin
                        re_min_q   <= bus.re_min;
                        step_q     <= bus.step;
                        max_iter_q <= bus.max_iter_in;
                        x          <= '0;
                        y          <= '0;
                        re_acc     <= bus.re_min;
                        im_acc     <= bus.im_max;
                    end
                end
                ST_WAIT: begin
                    if (complete) depth_q <= bus.calc_depth;
                end
                ST_OUTPUT: begin
                    if (bus.pix_ready && !last_pix) begin
                        if (x != X_LAST) begin
                            x      <= x + 10'd1;
                            re_acc <= re_acc + step_q;
                        end else begin
                            // Row wrap: imaginary axis walks downward from im_max.
                            x      <= '0;
                            y      <= y + 9'd1;
                            re_acc <= re_min_q;
                            im_acc <= im_acc - step_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.calc_start    = (state == ST_ISSUE);
    assign bus.calc_x        = x;
    assign bus.calc_y        = y;
    assign bus.calc_re_c     = re_acc;
    assign bus.calc_im_c     = im_acc;
    assign bus.calc_max_iter = max_iter_q;

    assign bus.pix_valid = (state == ST_OUTPUT);
    assign bus.pix_x     = x;
    assign bus.pix_y     = y;
    assign bus.pix_depth = depth_q;
    assign bus.pix_last  = (state == ST_OUTPUT) && last_pix;
    assign bus.busy      = (state != ST_IDLE);
endmodule
